// File: rtl/save_ram_ctrl.sv
// Save-RAM arbiter: bridge loader/unloader vs. core accesses, with load/flush mode tracking.
// Optional autosave request generator is compiled in when SAVE_RAM_AUTOSAVE_EN is defined.
module save_ram_ctrl #(
  parameter int          AW          = 17,
  parameter int          DW          = 8,
  parameter int          RAM_LAT     = 1,
  parameter logic [23:0] IDLE_CYCLES = 24'd7_400_000
) (
  input  logic          clk_memory,
  input  logic          reset,
  input  logic          nvram_download,
  input  logic          nvram_upload,
  input  logic          nvram_wr,
  input  logic [AW-1:0] nvram_addr,
  input  logic [DW-1:0] nvram_dout,
  input  logic          nvram_rd,
  output logic [DW-1:0] nvram_din,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ack,
  output logic          core_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          save_dirty,
  output logic          nvram_upload_req
);

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} mode_t;
  mode_t mode_reg;

  logic               bridge_op;
  logic               bridge_wr;
  logic               bridge_rd;
  logic               core_ok;
  logic               core_issue;
  logic               core_wr_issue;
  logic               core_rd_issue;
  logic               core_rd_pending_reg;
  logic               core_rd_ack_reg;
  logic               save_dirty_reg;
  logic [DW-1:0]      nvram_din_reg;
  logic [DW-1:0]      core_rdata_reg;
  logic [RAM_LAT-1:0] tag_valid_reg;
  logic [RAM_LAT-1:0] tag_core_reg;

  // Bridge strobes always win the RAM port; the core only gets idle cycles.
  assign bridge_op     = nvram_wr || nvram_rd;
  assign bridge_wr     = !reset && nvram_wr;
  assign bridge_rd     = !reset && nvram_rd && !nvram_wr;
  assign core_ok       = (mode_reg == RUN) || ((mode_reg == FLUSH) && !core_we);
  assign core_issue    = !reset && !bridge_op && core_req && !core_rd_pending_reg && core_ok;
  assign core_wr_issue = core_issue && core_we;
  assign core_rd_issue = core_issue && !core_we;

  assign ram_addr  = bridge_op ? nvram_addr : core_addr;
  assign ram_wdata = nvram_wr ? nvram_dout : core_wdata;
  assign ram_we    = bridge_wr || core_wr_issue;

  always_ff @(posedge clk_memory) begin
    if (reset) begin
      mode_reg <= RUN;
    end else begin
      case (mode_reg)
        RUN: begin
          if (nvram_download)    mode_reg <= LOAD;
          else if (nvram_upload) mode_reg <= FLUSH;
        end
        LOAD:    if (!nvram_download) mode_reg <= RUN;
        FLUSH:   if (!nvram_upload)   mode_reg <= RUN;
        default: mode_reg <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_memory) begin
    if (reset) begin
      tag_valid_reg       <= '0;
      tag_core_reg        <= '0;
      core_rd_pending_reg <= 1'b0;
      core_rd_ack_reg     <= 1'b0;
      nvram_din_reg       <= '0;
      core_rdata_reg      <= '0;
      save_dirty_reg      <= 1'b0;
    end else begin
      tag_valid_reg[0] <= bridge_rd || core_rd_issue;
      tag_core_reg[0]  <= core_rd_issue;
      for (int i = 1; i < RAM_LAT; i++) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_core_reg[i]  <= tag_core_reg[i-1];
      end

      core_rd_ack_reg <= 1'b0;
      if (tag_valid_reg[RAM_LAT-1]) begin
        if (tag_core_reg[RAM_LAT-1]) begin
          core_rdata_reg  <= ram_rdata;
          core_rd_ack_reg <= 1'b1;
        end else begin
          nvram_din_reg <= ram_rdata;
        end
      end

      // Pending covers the ack cycle too, so a still-high core_req is not re-issued.
      if (core_rd_issue)        core_rd_pending_reg <= 1'b1;
      else if (core_rd_ack_reg) core_rd_pending_reg <= 1'b0;

      if ((mode_reg == RUN) && nvram_download)    save_dirty_reg <= 1'b0;
      else if ((mode_reg == FLUSH) && !nvram_upload) save_dirty_reg <= 1'b0;
      else if (core_wr_issue)                     save_dirty_reg <= 1'b1;
    end
  end

  assign nvram_din  = nvram_din_reg;
  assign core_rdata = core_rdata_reg;
  assign core_ack   = !reset && (core_rd_ack_reg || core_wr_issue);
  assign core_busy  = !reset && ((mode_reg == LOAD) ||
                                 ((mode_reg == FLUSH) && core_req && core_we));
  assign save_dirty = save_dirty_reg;

`ifdef SAVE_RAM_AUTOSAVE_EN
  logic [23:0] idle_cnt_reg;
  logic        upload_req_reg;

  // Counter saturates at IDLE_CYCLES, so the request fires once per dirty episode.
  always_ff @(posedge clk_memory) begin
    if (reset) begin
      idle_cnt_reg   <= '0;
      upload_req_reg <= 1'b0;
    end else begin
      upload_req_reg <= 1'b0;
      if (core_wr_issue) begin
        idle_cnt_reg <= '0;
      end else if (save_dirty_reg && (mode_reg == RUN) && (idle_cnt_reg != IDLE_CYCLES)) begin
        idle_cnt_reg <= idle_cnt_reg + 24'd1;
        if (idle_cnt_reg == IDLE_CYCLES - 24'd1) upload_req_reg <= 1'b1;
      end
    end
  end

  assign nvram_upload_req = upload_req_reg;
`else
  logic unused_idle_cycles;
  assign unused_idle_cycles = ^IDLE_CYCLES;
  assign nvram_upload_req   = 1'b0;
`endif

endmodule

// File: tb/tb_save_ram_ctrl.sv
// Directed bench for save_ram_ctrl (RAM_LAT=2, 8-bit address) with a latency-accurate RAM model.
module tb_save_ram_ctrl;

  logic       clk_memory;
  logic       reset;
  logic       nvram_download;
  logic       nvram_upload;
  logic       nvram_wr;
  logic [7:0] nvram_addr;
  logic [7:0] nvram_dout;
  logic       nvram_rd;
  logic [7:0] nvram_din;
  logic       core_req;
  logic       core_we;
  logic [7:0] core_addr;
  logic [7:0] core_wdata;
  logic [7:0] core_rdata;
  logic       core_ack;
  logic       core_busy;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic       save_dirty;
  logic       nvram_upload_req;

  save_ram_ctrl #(
    .AW(8), .DW(8), .RAM_LAT(2), .IDLE_CYCLES(24'd100)
  ) dut (
    .clk_memory(clk_memory), .reset(reset),
    .nvram_download(nvram_download), .nvram_upload(nvram_upload),
    .nvram_wr(nvram_wr), .nvram_addr(nvram_addr), .nvram_dout(nvram_dout),
    .nvram_rd(nvram_rd), .nvram_din(nvram_din),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
    .core_busy(core_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .save_dirty(save_dirty), .nvram_upload_req(nvram_upload_req)
  );

  initial clk_memory = 1'b0;
  always #5 clk_memory = ~clk_memory;

  // External save RAM: data valid two cycles after the address is presented.
  logic [7:0] mem [256];
  logic [7:0] rd_pipe1, rd_pipe2;
  always @(posedge clk_memory) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_pipe1 <= mem[ram_addr];
    rd_pipe2 <= rd_pipe1;
  end
  assign ram_rdata = rd_pipe2;

  typedef enum logic [1:0] {K_BW, K_BR, K_CW, K_CR} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] addr;
    logic [7:0] data;  // write data, or expected read data
  } vec_t;

  vec_t       vecs [14];
  logic [7:0] baddr [8];
  logic [7:0] bexp [8];
  logic [7:0] last_din;
  int         n_checks;
  int         n_fail;

  task automatic step();
    @(posedge clk_memory);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts at the beginning of a cycle with all strobes low; returns the same way.
  task automatic run_vec(input vec_t v);
    int lat;
    $display("txn kind=%0d addr=%02h data=%02h", v.kind, v.addr, v.data);
    case (v.kind)
      K_BW: begin
        nvram_wr = 1'b1; nvram_addr = v.addr; nvram_dout = v.data;
        #1;
        chk("bw_we", ram_we, 1);
        chk("bw_wdata", ram_wdata, v.data);
        step();
        nvram_wr = 1'b0;
      end
      K_BR: begin
        nvram_rd = 1'b1; nvram_addr = v.addr;
        step();
        nvram_rd = 1'b0;
        step();
        #1;
        chk("br_hold", nvram_din, last_din);
        step();
        #1;
        chk("br_data", nvram_din, v.data);
        last_din = v.data;
        step();
      end
      K_CW: begin
        core_req = 1'b1; core_we = 1'b1; core_addr = v.addr; core_wdata = v.data;
        #1;
        chk("cw_ack", core_ack, 1);
        chk("cw_we", ram_we, 1);
        step();
        core_req = 1'b0;
        #1;
        chk("cw_dirty", save_dirty, 1);
      end
      K_CR: begin
        core_req = 1'b1; core_we = 1'b0; core_addr = v.addr;
        lat = 0;
        #1;
        while (!core_ack && lat < 8) begin
          step();
          #1;
          lat++;
        end
        chk("cr_latency", lat, 3);
        chk("cr_data", core_rdata, v.data);
        step();
        core_req = 1'b0;
      end
      default: ;
    endcase
  endtask

  initial begin
    vec_t v;
    int   pulses;
    int   first;
    n_checks = 0; n_fail = 0; last_din = 8'h00;

    vecs[0]  = '{K_BW, 8'h11, 8'h3C};
    vecs[1]  = '{K_BW, 8'h12, 8'hC3};
    vecs[2]  = '{K_BW, 8'hFF, 8'h7E};
    vecs[3]  = '{K_BR, 8'h10, 8'hA5};
    vecs[4]  = '{K_BR, 8'hFF, 8'h7E};
    vecs[5]  = '{K_CW, 8'h30, 8'h99};
    vecs[6]  = '{K_CR, 8'h30, 8'h99};
    vecs[7]  = '{K_CR, 8'h11, 8'h3C};
    vecs[8]  = '{K_BR, 8'h30, 8'h99};
    vecs[9]  = '{K_CW, 8'h00, 8'h01};
    vecs[10] = '{K_BR, 8'h00, 8'h01};
    vecs[11] = '{K_CR, 8'h12, 8'hC3};
    vecs[12] = '{K_BR, 8'h12, 8'hC3};
    vecs[13] = '{K_CR, 8'hFF, 8'h7E};
    baddr[0] = 8'h10; baddr[1] = 8'h11; baddr[2] = 8'h12; baddr[3] = 8'hFF;
    baddr[4] = 8'h30; baddr[5] = 8'h00; baddr[6] = 8'h20; baddr[7] = 8'h10;
    bexp[0]  = 8'hA5; bexp[1]  = 8'h3C; bexp[2]  = 8'hC3; bexp[3]  = 8'h7E;
    bexp[4]  = 8'h99; bexp[5]  = 8'h01; bexp[6]  = 8'h11; bexp[7]  = 8'hA5;

    // Reset with a bridge write held: it must not reach the RAM until reset drops.
    reset = 1'b1; nvram_download = 1'b0; nvram_upload = 1'b0;
    nvram_wr = 1'b1; nvram_addr = 8'h10; nvram_dout = 8'hA5; nvram_rd = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    step();
    step();
    #1;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_core_ack", core_ack, 0);
    chk("rst_core_busy", core_busy, 0);
    chk("rst_nvram_din", nvram_din, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_save_dirty", save_dirty, 0);
    chk("rst_upload_req", nvram_upload_req, 0);
    step();
    reset = 1'b0;
    #1;
    chk("first_op_we", ram_we, 1);
    step();
    nvram_wr = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Bridge write and core write to the same address in the same cycle.
    $display("txn collision addr=20");
    nvram_wr = 1'b1; nvram_addr = 8'h20; nvram_dout = 8'h22;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h11;
    #1;
    chk("coll_ack_first", core_ack, 0);
    chk("coll_bridge_wdata", ram_wdata, 8'h22);
    step();
    nvram_wr = 1'b0;
    #1;
    chk("coll_ack_late", core_ack, 1);
    chk("coll_core_wdata", ram_wdata, 8'h11);
    step();
    core_req = 1'b0;
    v = '{K_BR, 8'h20, 8'h11};
    run_vec(v);

    // Eight back-to-back bridge reads with a core read held underneath.
    $display("txn burst 8 bridge reads + core read 11");
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h11;
    for (int c = 0; c < 13; c++) begin
      nvram_rd = (c < 8);
      if (c < 8) nvram_addr = baddr[c];
      #1;
      if (c >= 3 && c < 11) chk("burst_din", nvram_din, bexp[c-3]);
      chk("burst_ack", core_ack, (c == 11));
      if (c == 11) chk("burst_rdata", core_rdata, 8'h3C);
      step();
      if (c == 11) core_req = 1'b0;
    end
    nvram_rd = 1'b0;
    last_din = 8'hA5;

    // Download while a core read is waiting.
    $display("txn download with core read 12 waiting");
    chk("dl_dirty_before", save_dirty, 1);
    nvram_download = 1'b1;
    step();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h12;
    for (int c = 0; c < 5; c++) begin
      nvram_wr = (c == 2); nvram_addr = 8'h40; nvram_dout = 8'h5E;
      #1;
      chk("dl_busy", core_busy, 1);
      chk("dl_ack", core_ack, 0);
      chk("dl_we", ram_we, (c == 2));
      if (c == 0) chk("dl_dirty", save_dirty, 0);
      step();
    end
    nvram_wr = 1'b0;
    nvram_download = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("dl_end_busy", core_busy, (c == 0));
      chk("dl_end_ack", core_ack, (c == 4));
      if (c == 4) chk("dl_end_rdata", core_rdata, 8'hC3);
      step();
      if (c == 4) core_req = 1'b0;
    end

    // Flush: writes blocked, reads allowed, mode change while a read is in flight.
    v = '{K_CW, 8'h31, 8'h42};
    run_vec(v);
    $display("txn flush blocked write, read 31 across flush exit");
    nvram_upload = 1'b1;
    step();
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h31; core_wdata = 8'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("fl_wr_busy", core_busy, 1);
      chk("fl_wr_ack", core_ack, 0);
      chk("fl_wr_we", ram_we, 0);
      chk("fl_wr_dirty", save_dirty, 1);
      step();
    end
    core_req = 1'b0;
    step();
    core_req = 1'b1; core_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) nvram_upload = 1'b0;
      #1;
      chk("fl_rd_busy", core_busy, 0);
      chk("fl_rd_ack", core_ack, (c == 3));
      if (c == 3) chk("fl_rd_rdata", core_rdata, 8'h42);
      chk("fl_dirty", save_dirty, (c < 2));
      step();
      if (c == 3) core_req = 1'b0;
    end

    // Reset while a core read is outstanding.
    v = '{K_CW, 8'h32, 8'h77};
    run_vec(v);
    $display("txn reset during core read 30");
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h30;
    step();
    core_req = 1'b0; reset = 1'b1;
    #1;
    chk("rs_mid_ack", core_ack, 0);
    chk("rs_mid_we", ram_we, 0);
    step();
    reset = 1'b0;
    #1;
    chk("rs_nvram_din", nvram_din, 0);
    chk("rs_core_rdata", core_rdata, 0);
    chk("rs_core_ack", core_ack, 0);
    chk("rs_core_busy", core_busy, 0);
    chk("rs_save_dirty", save_dirty, 0);
    chk("rs_upload_req", nvram_upload_req, 0);
    chk("rs_ram_we", ram_we, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      #1;
      chk("rs_no_ack", core_ack, 0);
    end
    step();
    last_din = 8'h00;
    v = '{K_CR, 8'h30, 8'h99};
    run_vec(v);

    // Autosave request after a single core write.
    $display("txn autosave window after core write 33");
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h33; core_wdata = 8'h5A;
    #1;
    chk("as_ack", core_ack, 1);
    step();
    core_req = 1'b0;
    pulses = 0; first = -1;
    for (int c = 1; c <= 200; c++) begin
      #1;
      if (nvram_upload_req) begin
        pulses++;
        if (first < 0) first = c;
      end
      step();
    end
`ifdef SAVE_RAM_AUTOSAVE_EN
    chk("as_pulse_count", pulses, 1);
    chk("as_pulse_offset", first, 101);
`else
    chk("as_no_pulse", pulses, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
